// File: rtl/or_accum_pkg.sv
// Shared types and default sizes for the OR-accumulate scheduler.
package or_accum_pkg;

    localparam int ACC_DEPTH = 256;
    localparam int ACC_W     = 32;
    localparam int ACC_IDXW  = $clog2(ACC_DEPTH);
    localparam int ACC_SHW   = $clog2(ACC_W);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } acc_state_e;

    // One pending update: target word and the already-shifted OR mask.
    typedef struct packed {
        logic [ACC_IDXW-1:0] idx;
        logic [ACC_W-1:0]    data;
    } acc_upd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating
// pointer; the pointer moves just past the winner on every grant.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic          found;

    // Pick the winner by scanning from the pointer, wrapping modulo N.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        gnt      = '0;
        ptr_next = ptr;
        found    = 1'b0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                if (!found && req[(int'(ptr) + k) % N]) begin
                    found                      = 1'b1;
                    gnt[(int'(ptr) + k) % N]   = 1'b1;
                    ptr_next                   = PW'((int'(ptr) + k + 1) % N);
                end
            end
        end
    end

    // Pointer only moves when someone was granted.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) ptr <= '0;
        else     ptr <= ptr_next;
    end

endmodule

// File: rtl/or_accum_sched.sv
// Shared DEPTH x W OR-accumulate register file with round-robin update
// requesters, one read port with stage-1 forwarding, and a clear sweep.
module or_accum_sched
    import or_accum_pkg::*;
#(
    parameter int DEPTH = ACC_DEPTH,
    parameter int W     = ACC_W,
    parameter int NREQ  = 2,
    parameter int IDXW  = $clog2(DEPTH),
    parameter int SHW   = $clog2(W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_req,
    output logic               clr_busy,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*IDXW-1:0] req_idx,
    input  logic [NREQ*W-1:0]  req_val,
    input  logic [NREQ*SHW-1:0] req_sh,
    input  logic               rd_valid,
    output logic               rd_ready,
    input  logic [IDXW-1:0]    rd_idx,
    output logic               rsp_valid,
    output logic [W-1:0]       rsp_data
);

    acc_state_e      state;
    logic [IDXW-1:0] clr_ptr;
    acc_upd_t        s1;
    logic            s1_valid;
    logic [W-1:0]    mem [DEPTH];

    logic            arb_en;
    logic [NREQ-1:0] gnt;
    logic            any_gnt;
    logic [IDXW-1:0] sel_idx;
    logic [W-1:0]    sel_data;
    logic            rd_accept;

    // Grants are only issued in RUN, and a clear request suppresses them.
    assign arb_en    = (state == RUN) && !clr_req;
    assign req_ready = gnt;
    assign any_gnt   = |gnt;
    assign rd_ready  = (state == RUN);
    assign clr_busy  = (state != RUN);
    assign rd_accept = rd_valid && (state == RUN);

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .en  (arb_en),
        .gnt (gnt)
    );

    // Route the granted requester's fields and pre-shift its value.
    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_idx  = req_idx[i*IDXW +: IDXW];
                sel_data = req_val[i*W +: W] << req_sh[i*SHW +: SHW];
            end
        end
    end

    // Sweep FSM: CLEAR walks every word once, RUN serves traffic, DRAIN lets stage 1 retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == IDXW'(DEPTH - 1)) state <= RUN;
                end
                RUN: begin
                    if (clr_req) state <= DRAIN;
                end
                DRAIN: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Stage-1 register holds the accepted update for one cycle before the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            s1_valid <= any_gnt;
            if (any_gnt) begin
                s1.idx  <= sel_idx;
                s1.data <= sel_data;
            end
        end
    end

    // Single write port: sweep zeroing in CLEAR, otherwise the OR commit of stage 1.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; its contents are defined only by the clear sweep.
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (s1_valid) begin
                mem[s1.idx] <= mem[s1.idx] | s1.data;
            end
        end
    end

    // Read response: array word merged with any not-yet-committed stage-1 update.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rd_accept;
            if (rd_accept) begin
                rsp_data <= mem[rd_idx] |
                            ((s1_valid && (s1.idx == rd_idx)) ? s1.data : '0);
            end
        end
    end

endmodule
